// File: rtl/mmu_arbiter.sv
// mmu_arbiter
//   Arbitrates three translation requesters (inst, load, store) onto a
//   single MMU port. Each translation runs IDLE -> ISSUE -> CAPTURE -> RESP:
//   the winner is accepted in IDLE, the MMU strobe fires in ISSUE, the MMU
//   exception code is registered in CAPTURE, and the result is held in RESP
//   until the consumer takes it.
//
//   Per-requester 4-bit saturating starvation counters override the normal
//   policy once a requester has waited long enough.
//
//   Build option: define MMU_ARB_RR_EN to use a round-robin normal policy.
//   Without it the normal policy is fixed priority inst > load > store.
//
// Ports
//   clk, reset             core clock, asynchronous active-high reset
//   flush_i                abandons the in-flight translation / blocks grant
//   req_valid_i[2:0]       request per requester (0 inst, 1 load, 2 store)
//   req_addr_i, req_bytes_i  per-requester virtual address and access size
//   req_ready_o[2:0]       one-hot accept pulse (IDLE only)
//   mmu_addr_o, mmu_bytes_o  latched address/size to the MMU
//   mmu_inst_o/ld_o/st_o   one-cycle MMU access strobe (ISSUE only)
//   mmu_exc_i              MMU exception code, valid the cycle after strobe
//   resp_valid_o, resp_id_o, resp_exc_o, resp_ready_i  result handshake

`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef SIZE_DATA_BYTE_OFFSET
`define SIZE_DATA_BYTE_OFFSET 4
`endif

module mmu_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    flush_i,
    input  logic [2:0]                              req_valid_i,
    input  logic [2:0][`SIZE_DATA-1:0]              req_addr_i,
    input  logic [2:0][`SIZE_DATA_BYTE_OFFSET-1:0]  req_bytes_i,
    output logic [2:0]                              req_ready_o,
    output logic [`SIZE_DATA-1:0]                   mmu_addr_o,
    output logic [`SIZE_DATA_BYTE_OFFSET-1:0]       mmu_bytes_o,
    output logic                                    mmu_ld_o,
    output logic                                    mmu_st_o,
    output logic                                    mmu_inst_o,
    input  logic [7:0]                              mmu_exc_i,
    output logic                                    resp_valid_o,
    output logic [1:0]                              resp_id_o,
    output logic [7:0]                              resp_exc_o,
    input  logic                                    resp_ready_i
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t                              r_state;
    state_t                              w_state_next;

    logic [2:0][3:0]                     r_starve_cnt;
    logic [`SIZE_DATA-1:0]               r_addr;
    logic [`SIZE_DATA_BYTE_OFFSET-1:0]   r_bytes;
    logic [1:0]                          r_id;
    logic [7:0]                          r_exc;

    logic                                w_arb_en;
    logic                                w_take;
    logic [2:0]                          w_starved;
    logic [2:0]                          w_grant;
    logic [1:0]                          w_win_id;

    // Arbitration happens only in IDLE, never under flush; reset is folded
    // in so req_ready_o drops the instant reset is asserted.
    assign w_arb_en = (r_state == S_IDLE) && !flush_i && !reset;
    assign w_take   = w_arb_en && (|req_valid_i);

    // Starvation counters. A requester is treated as starved when losing
    // this arbitration would bring its counter to STARVE_LIMIT, so with a
    // limit of 8 it is force-granted instead of taking its 8th loss.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_req
            assign w_starved[gi] = req_valid_i[gi] &&
                                   ((int'(r_starve_cnt[gi]) + 1) >= STARVE_LIMIT);
            assign w_grant[gi]   = w_take && (w_win_id == 2'(gi));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_starve_cnt[gi] <= 4'd0;
                end else if (w_arb_en) begin
                    if (!req_valid_i[gi] || w_grant[gi]) begin
                        r_starve_cnt[gi] <= 4'd0;
                    end else if (r_starve_cnt[gi] != 4'hF) begin
                        r_starve_cnt[gi] <= r_starve_cnt[gi] + 4'd1;
                    end
                end
            end
        end
    endgenerate

`ifdef MMU_ARB_RR_EN
    logic [1:0] r_rr_ptr;
    logic [1:0] w_rr_start;

    assign w_rr_start = (r_rr_ptr == 2'd2) ? 2'd0 : (r_rr_ptr + 2'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= 2'd0;
        end else if (w_take) begin
            r_rr_ptr <= w_win_id;
        end
    end
`endif

    // Winner select: starved requesters first (inst > load > store),
    // otherwise the normal policy. Only meaningful when w_take is high.
    always_comb begin
        w_win_id = 2'd0;
        if (|w_starved) begin
            if (w_starved[0])      w_win_id = 2'd0;
            else if (w_starved[1]) w_win_id = 2'd1;
            else                   w_win_id = 2'd2;
        end else begin
`ifdef MMU_ARB_RR_EN
            // Walk offsets from farthest to nearest so the nearest valid
            // requester after the pointer is the one left standing.
            for (int off = 2; off >= 0; off--) begin
                if (req_valid_i[(int'(w_rr_start) + off) % 3]) begin
                    w_win_id = 2'((int'(w_rr_start) + off) % 3);
                end
            end
`else
            if (req_valid_i[0])      w_win_id = 2'd0;
            else if (req_valid_i[1]) w_win_id = 2'd1;
            else                     w_win_id = 2'd2;
`endif
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state; flush abandons the translation from any busy state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_take) w_state_next = S_ISSUE;
            S_ISSUE:   w_state_next = flush_i ? S_IDLE : S_CAPTURE;
            S_CAPTURE: w_state_next = flush_i ? S_IDLE : S_RESP;
            S_RESP:    if (flush_i || resp_ready_i) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Request latch and exception capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_bytes <= '0;
            r_id    <= 2'd0;
            r_exc   <= 8'd0;
        end else begin
            if (w_take) begin
                r_addr  <= req_addr_i[w_win_id];
                r_bytes <= req_bytes_i[w_win_id];
                r_id    <= w_win_id;
            end
            if ((r_state == S_CAPTURE) && !flush_i) begin
                r_exc <= mmu_exc_i;
            end
        end
    end

    assign req_ready_o  = w_grant;
    assign mmu_addr_o   = r_addr;
    assign mmu_bytes_o  = r_bytes;
    assign mmu_inst_o   = (r_state == S_ISSUE) && (r_id == 2'd0);
    assign mmu_ld_o     = (r_state == S_ISSUE) && (r_id == 2'd1);
    assign mmu_st_o     = (r_state == S_ISSUE) && (r_id == 2'd2);
    assign resp_valid_o = (r_state == S_RESP);
    assign resp_id_o    = r_id;
    assign resp_exc_o   = r_exc;

endmodule

// File: tb/tb_mmu_arbiter.sv
// tb_mmu_arbiter
//   Self-checking bench for mmu_arbiter: a table of single translations
//   followed by hand-written multi-cycle sequences (backpressure, flush,
//   reset mid-translation, starvation / round-robin ordering).

`timescale 1ns/1ps

`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef SIZE_DATA_BYTE_OFFSET
`define SIZE_DATA_BYTE_OFFSET 4
`endif

module tb_mmu_arbiter;

    localparam int AW = `SIZE_DATA;
    localparam int BW = `SIZE_DATA_BYTE_OFFSET;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   flush_i;
    logic [2:0]             req_valid_i;
    logic [2:0][AW-1:0]     req_addr_i;
    logic [2:0][BW-1:0]     req_bytes_i;
    logic [2:0]             req_ready_o;
    logic [AW-1:0]          mmu_addr_o;
    logic [BW-1:0]          mmu_bytes_o;
    logic                   mmu_ld_o;
    logic                   mmu_st_o;
    logic                   mmu_inst_o;
    logic [7:0]             mmu_exc_i;
    logic                   resp_valid_o;
    logic [1:0]             resp_id_o;
    logic [7:0]             resp_exc_o;
    logic                   resp_ready_i;

    mmu_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (flush_i),
        .req_valid_i  (req_valid_i),
        .req_addr_i   (req_addr_i),
        .req_bytes_i  (req_bytes_i),
        .req_ready_o  (req_ready_o),
        .mmu_addr_o   (mmu_addr_o),
        .mmu_bytes_o  (mmu_bytes_o),
        .mmu_ld_o     (mmu_ld_o),
        .mmu_st_o     (mmu_st_o),
        .mmu_inst_o   (mmu_inst_o),
        .mmu_exc_i    (mmu_exc_i),
        .resp_valid_o (resp_valid_o),
        .resp_id_o    (resp_id_o),
        .resp_exc_o   (resp_exc_o),
        .resp_ready_i (resp_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    valid;
        logic [AW-1:0] addr;
        logic [BW-1:0] bytes;
        logic [7:0]    exc;
        logic [1:0]    exp_fp;   // expected winner, fixed priority
        logic [1:0]    exp_rr;   // expected winner, round-robin from reset
    } vec_t;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] onehot(input logic [1:0] id);
        logic [2:0] r;
        r = 3'b001 << id;
        return r;
    endfunction

    function automatic logic [1:0] id_of(input logic [2:0] oh);
        logic [1:0] r;
        r = oh[2] ? 2'd2 : (oh[1] ? 2'd1 : 2'd0);
        return r;
    endfunction

    function automatic logic [2:0] strobes();
        logic [2:0] r;
        r = {mmu_st_o, mmu_ld_o, mmu_inst_o};
        return r;
    endfunction

    // One full translation with resp_ready_i raised on the first RESP cycle.
    task automatic run_vec(input int idx, input vec_t v, input logic [1:0] exp_id);
        logic [AW-1:0] ea;
        logic [BW-1:0] eb;
        ea = v.addr + AW'(exp_id) * AW'(32'h100);
        eb = v.bytes + BW'(exp_id);
        for (int k = 0; k < 3; k++) begin
            req_addr_i[k]  = v.addr + AW'(k) * AW'(32'h100);
            req_bytes_i[k] = v.bytes + BW'(k);
        end
        req_valid_i = v.valid;
        #1;
        chk("vec_ready", 64'(req_ready_o), 64'(onehot(exp_id)));
        tick();                                   // ISSUE
        req_valid_i = 3'b000;
        chk("vec_strobe", 64'(strobes()), 64'(onehot(exp_id)));
        chk("vec_addr", 64'(mmu_addr_o), 64'(ea));
        chk("vec_bytes", 64'(mmu_bytes_o), 64'(eb));
        tick();                                   // CAPTURE
        mmu_exc_i = v.exc;
        chk("vec_capture_strobe", 64'(strobes()), 64'd0);
        chk("vec_capture_nvalid", 64'(resp_valid_o), 64'd0);
        tick();                                   // RESP
        mmu_exc_i = 8'hEE;
        chk("vec_resp_valid", 64'(resp_valid_o), 64'd1);
        chk("vec_resp_id", 64'(resp_id_o), 64'(exp_id));
        chk("vec_resp_exc", 64'(resp_exc_o), 64'(v.exc));
        chk("vec_addr_hold", 64'(mmu_addr_o), 64'(ea));
        resp_ready_i = 1'b1;
        tick();                                   // IDLE
        resp_ready_i = 1'b0;
        mmu_exc_i = 8'h00;
        chk("vec_resp_done", 64'(resp_valid_o), 64'd0);
        $display("vec %0d: valid=%b winner=%0d exc=0x%02h", idx, v.valid, exp_id, v.exc);
    endtask

    vec_t vecs[7];

    initial begin
        int           seen;
        int           n_grants;
        int           last_cyc;
        logic [1:0]   exp_seq[9];
        logic [1:0]   g;

        vecs[0] = '{valid: 3'b010, addr: 32'h0000_1000, bytes: 4'd3, exc: 8'h00, exp_fp: 2'd1, exp_rr: 2'd1};
        vecs[1] = '{valid: 3'b100, addr: 32'h0000_2003, bytes: 4'd1, exc: 8'h05, exp_fp: 2'd2, exp_rr: 2'd2};
        vecs[2] = '{valid: 3'b001, addr: 32'hABCD_0000, bytes: 4'd4, exc: 8'h0D, exp_fp: 2'd0, exp_rr: 2'd0};
        vecs[3] = '{valid: 3'b111, addr: 32'h0001_0000, bytes: 4'd2, exc: 8'h11, exp_fp: 2'd0, exp_rr: 2'd1};
        vecs[4] = '{valid: 3'b110, addr: 32'h0002_0000, bytes: 4'd7, exc: 8'h00, exp_fp: 2'd1, exp_rr: 2'd2};
        vecs[5] = '{valid: 3'b011, addr: 32'h0003_0000, bytes: 4'd0, exc: 8'hFF, exp_fp: 2'd0, exp_rr: 2'd0};
        vecs[6] = '{valid: 3'b101, addr: 32'h0004_0000, bytes: 4'd5, exc: 8'h42, exp_fp: 2'd0, exp_rr: 2'd2};

        reset = 1'b1;
        flush_i = 1'b0;
        req_valid_i = 3'b111;
        req_addr_i = '0;
        req_bytes_i = '0;
        mmu_exc_i = 8'h00;
        resp_ready_i = 1'b0;

        // Reset state (requests held high to show ready stays low)
        tick();
        tick();
        chk("rst_ready", 64'(req_ready_o), 64'd0);
        chk("rst_strobes", 64'(strobes()), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        chk("rst_resp_id", 64'(resp_id_o), 64'd0);
        chk("rst_resp_exc", 64'(resp_exc_o), 64'd0);
        req_valid_i = 3'b000;
        reset = 1'b0;

        // Table-driven translations, first one in the first IDLE cycle
        for (int i = 0; i < 7; i++) begin
`ifdef MMU_ARB_RR_EN
            run_vec(i, vecs[i], vecs[i].exp_rr);
`else
            run_vec(i, vecs[i], vecs[i].exp_fp);
`endif
        end

        // Backpressure: store 0x2003, MMU returns 0x05, ready low 5 cycles
        req_addr_i[2] = 32'h0000_2003;
        req_bytes_i[2] = 4'd1;
        req_valid_i = 3'b100;
        #1;
        chk("bp_ready", 64'(req_ready_o), 64'(3'b100));
        tick();
        req_valid_i = 3'b000;
        chk("bp_strobe", 64'(strobes()), 64'(3'b100));
        tick();
        mmu_exc_i = 8'h05;
        tick();
        mmu_exc_i = 8'h00;
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", 64'(resp_valid_o), 64'd1);
            chk("bp_id", 64'(resp_id_o), 64'd2);
            chk("bp_exc", 64'(resp_exc_o), 64'h05);
            chk("bp_addr_hold", 64'(mmu_addr_o), 64'h2003);
            tick();
        end
        resp_ready_i = 1'b1;
        chk("bp_valid_at_ready", 64'(resp_valid_o), 64'd1);
        tick();
        resp_ready_i = 1'b0;
        chk("bp_released", 64'(resp_valid_o), 64'd0);
        req_valid_i = 3'b001;              // probe IDLE without a grant
        #1;
        chk("bp_idle_probe", 64'(req_ready_o), 64'(3'b001));
        req_valid_i = 3'b000;
        $display("seq backpressure: store exc=0x05 held 5 cycles");

        // Flush in CAPTURE with a pending load
        tick();
        req_valid_i = 3'b001;
        tick();                            // ISSUE (inst)
        req_valid_i = 3'b000;
        tick();                            // CAPTURE
        flush_i = 1'b1;
        req_addr_i[1] = 32'h0000_3000;
        req_valid_i = 3'b010;
        #1;
        chk("fc_ready_busy", 64'(req_ready_o), 64'd0);
        tick();                            // IDLE
        flush_i = 1'b0;
        #1;
        chk("fc_no_resp", 64'(resp_valid_o), 64'd0);
        chk("fc_load_grant", 64'(req_ready_o), 64'(3'b010));
        tick();                            // ISSUE (load)
        req_valid_i = 3'b000;
        chk("fc_ld_strobe", 64'(strobes()), 64'(3'b010));
        chk("fc_ld_addr", 64'(mmu_addr_o), 64'h3000);
        tick();
        mmu_exc_i = 8'h22;
        tick();
        mmu_exc_i = 8'h00;
        chk("fc_resp_id", 64'(resp_id_o), 64'd1);
        chk("fc_resp_exc", 64'(resp_exc_o), 64'h22);
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
        $display("seq flush-capture: load served after flush");

        // Flush in IDLE blocks the grant
        req_valid_i = 3'b001;
        flush_i = 1'b1;
        #1;
        chk("fi_no_ready", 64'(req_ready_o), 64'd0);
        tick();
        req_valid_i = 3'b000;
        flush_i = 1'b0;
        chk("fi_no_strobe", 64'(strobes()), 64'd0);

        // Flush in ISSUE: strobe still fires, no response follows
        req_valid_i = 3'b100;
        tick();
        req_valid_i = 3'b000;
        flush_i = 1'b1;
        #1;
        chk("fis_strobe", 64'(strobes()), 64'(3'b100));
        tick();
        flush_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (resp_valid_o) seen++;
            tick();
        end
        chk("fis_no_resp", 64'(seen), 64'd0);
        $display("seq flush-idle/issue: grant blocked, issue abandoned");

        // Reset during ISSUE
        req_valid_i = 3'b010;
        tick();
        req_valid_i = 3'b000;
        chk("ri_strobe", 64'(strobes()), 64'(3'b010));
        reset = 1'b1;
        #1;
        chk("ri_strobe_drop", 64'(strobes()), 64'd0);
        chk("ri_valid_drop", 64'(resp_valid_o), 64'd0);
        chk("ri_exc_clear", 64'(resp_exc_o), 64'd0);
        tick();
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (resp_valid_o || (strobes() != 3'b000)) seen++;
            tick();
        end
        chk("ri_no_resp", 64'(seen), 64'd0);
        $display("seq reset-in-issue: translation discarded");

        // Continuous contention, resp_ready tied high (counters/ptr just reset)
`ifdef MMU_ARB_RR_EN
        exp_seq = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
`else
        exp_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
`endif
        req_valid_i = 3'b111;
        resp_ready_i = 1'b1;
        mmu_exc_i = 8'h00;
        n_grants = 0;
        last_cyc = 0;
        #1;
        for (int c = 0; c < 80 && n_grants < 9; c++) begin
            if (req_ready_o != 3'b000) begin
                g = id_of(req_ready_o);
                chk("st_grant", 64'(g), 64'(exp_seq[n_grants]));
                if (n_grants > 0) chk("st_gap", 64'(c - last_cyc), 64'd4);
                $display("grant %0d: id %0d at cycle %0d", n_grants, g, c);
                last_cyc = c;
                n_grants++;
            end
            tick();
        end
        chk("st_grant_count", 64'(n_grants), 64'd9);
        req_valid_i = 3'b000;
        resp_ready_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
